ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port stack RAM between two requesters: port 0 = CPU core, port 1 = debug/loader.
//  Grants one transaction at a time and drives the RAM address/data/wren.
//  Handles RAM read latency and returns read data with a one-cycle ack pulse.
//  Sits between the core's RAM bus and the RAM macro.
// PARAMETERS
//  RD_LAT   1   RAM read latency, cycles from address-registering edge to q_ram valid; legal 1..4
//  PRIO0    0   0 = round-robin on ties; 1 = fixed priority, port 0 always wins ties
// PORTS
//  clock        in   1   single clock, all state on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  req0         in   1   port 0 request; held high until ack0
//  we0          in   1   port 0 write enable (1 = write, 0 = read); stable while req0
//  addr0        in   16  port 0 word address; stable while req0
//  wdata0       in   16  port 0 write data; stable while req0
//  ack0         out  1   port 0 completion, one-cycle pulse
//  rdata0       out  16  port 0 read data, valid with ack0, held until next port-0 read ack
//  req1/we1/addr1/wdata1/ack1/rdata1        same as port 0, for port 1
//  address_ram  out  16  RAM address
//  data_ram     out  16  RAM write data
//  wren_ram     out  1   RAM write enable
//  q_ram        in   16  RAM read data
//  busy         out  1   1 when state != IDLE
//  grant_id     out  1   owner of current/last transaction
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; wren_ram=0 immediately; ack0/1=0; rdata0/1=0.
//    address_ram=0, data_ram=0, grant_id=0, last_grant=1 (port 0 wins first tie).
//    Reset mid-transaction aborts it with no ack.
//  All outputs are registered.
//  FSM:
//   IDLE: sample req0/req1.
//     - One request high: grant that port.
//     - Both high: PRIO0=0 grants port != last_grant; PRIO0=1 grants port 0.
//     - On grant: latch addr/wdata into address_ram/data_ram, set grant_id, update last_grant, -> ISSUE.
//     - No request: stay IDLE; address_ram/data_ram hold their values.
//   ISSUE (1 cycle): wren_ram=1 only here, and only for writes.
//     - Write -> RESP. Read -> WAIT with counter = RD_LAT.
//   WAIT: decrement counter; on the cycle counter==1, capture q_ram into rdata[grant_id] -> RESP.
//   RESP: ack[grant_id]=1 for exactly this cycle -> IDLE. The other port's ack/rdata are untouched.
//  Latency, with request seen in IDLE at cycle T:
//    ISSUE at T+1; write ack at T+2; read ack at T+2+RD_LAT.
//    Throughput: write 3 cycles, read 3+RD_LAT cycles.
//  Arbitration occurs only in IDLE; no preemption. A newly arriving req waits for RESP->IDLE.
//  Requester deasserting req mid-transaction (protocol violation): transaction still completes and ack still pulses.
//  A req still high in the IDLE cycle after its ack is a new request.
//  Writes never modify rdata.
//  PRIO0=1 may starve port 1; this is accepted (debug port).
// STRUCTURE
//  team1_pkg: typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}; localparams ADDR_W=16, DATA_W=16.
//  Sub-module rr_arb2: combinational 2-way picker (req0, req1, last_grant, PRIO0) -> grant valid + grant index.
//  FSM, counter and output registers stay in ram_arbiter.
// TESTING
//  Bench uses a RAM model honouring RD_LAT.
//  1. Reset: assert reset_n=0 during a read WAIT -> wren_ram=0, busy=0, ack0/ack1=0 in the same cycle, no later ack.
//     After release with req0=req1=1 -> port 0 is granted first.
//  2. Write, port 0, addr0=0x0010, wdata0=0x1234, seen at T:
//     -> at T+1 only: wren_ram=1, address_ram=0x0010, data_ram=0x1234.
//     -> ack0=1 at T+2 only; ack1 never asserts.
//  3. Read, port 1, addr1=0x0010, RD_LAT=1, RAM holds 0x1234:
//     -> ack1 at T+3 with rdata1=0x1234; wren_ram stays 0; rdata0 unchanged.
//  4. Both ports issue continuous writes, PRIO0=0 -> grant_id sequence 0,1,0,1,...
//     -> each ack spaced 3 cycles, alternating ports.
//  5. PRIO0=1, both ports request continuously -> only port 0 is granted.
//     Drop req0 -> port 1 is granted at the next IDLE.
//  6. RD_LAT=3, port 0 read -> ack0 at T+5, rdata0=q_ram.
//     Repeat with req0 dropped at T+2 -> ack0 still pulses at T+5.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared types and widths for the stack-RAM arbiter.
//               ADDR_W / DATA_W : RAM bus widths.
//               arb_state_t     : arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Counter wide enough to hold the largest read latency (4).
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_rr_arb2
// Description : Combinational two-way request picker.
//               req0/req1   : requests from port 0 / port 1
//               last_grant  : port that won the previous arbitration
//               grant_valid : at least one request is pending
//               grant_idx   : index of the winning port
//               PRIO0 = 0 -> ties go to the port that did not win last;
//               PRIO0 = 1 -> ties always go to port 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_rr_arb2 #(
    parameter int PRIO0 = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        if (req0 && req1) begin
            grant_idx = (PRIO0 != 0) ? 1'b0 : ~last_grant;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
    end

endmodule : ram_arbiter_rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares a single-port stack RAM between the CPU core (port 0)
//               and the debug/loader (port 1). One transaction at a time;
//               read data is returned with a one-cycle ack pulse.
// Ports       : clock, reset_n (async, active low)
//               req/we/addr/wdata/ack/rdata 0 and 1 : requester buses
//               address_ram/data_ram/wren_ram/q_ram  : RAM macro interface
//               busy     : FSM not in IDLE
//               grant_id : owner of the current / last transaction
// Parameters  : RD_LAT (1..4) RAM read latency, PRIO0 tie-break mode
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int PRIO0  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] data_ram,
    output logic              wren_ram,
    input  logic [DATA_W-1:0] q_ram,
    output logic              busy,
    output logic              grant_id
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_last_grant;
    logic              r_grant_id;
    logic [ADDR_W-1:0] r_address_ram;
    logic [DATA_W-1:0] r_data_ram;
    logic              r_wren;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_busy;

    // Next-state values
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_we_nxt;
    logic              w_last_grant_nxt;
    logic              w_grant_id_nxt;
    logic [ADDR_W-1:0] w_address_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_wren_nxt;
    logic              w_ack0_nxt;
    logic              w_ack1_nxt;
    logic [DATA_W-1:0] w_rdata0_nxt;
    logic [DATA_W-1:0] w_rdata1_nxt;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_sel_we;

    ram_arbiter_rr_arb2 #(
        .PRIO0       (PRIO0)
    ) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (r_last_grant),
        .grant_valid (w_gnt_valid),
        .grant_idx   (w_gnt_idx)
    );

    assign w_sel_we = w_gnt_idx ? we1 : we0;

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Every output is registered, so the
    // values computed here are the ones that will be visible in the state
    // being entered (e.g. ack is set on the transition into RESP).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_we_nxt         = r_we;
        w_last_grant_nxt = r_last_grant;
        w_grant_id_nxt   = r_grant_id;
        w_address_nxt    = r_address_ram;
        w_data_nxt       = r_data_ram;
        w_wren_nxt       = 1'b0;
        w_ack0_nxt       = 1'b0;
        w_ack1_nxt       = 1'b0;
        w_rdata0_nxt     = r_rdata0;
        w_rdata1_nxt     = r_rdata1;

        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant_id_nxt   = w_gnt_idx;
                    w_last_grant_nxt = w_gnt_idx;
                    w_address_nxt    = w_gnt_idx ? addr1  : addr0;
                    w_data_nxt       = w_gnt_idx ? wdata1 : wdata0;
                    w_we_nxt         = w_sel_we;
                    // wren is high for the single ISSUE cycle of a write
                    w_wren_nxt       = w_sel_we;
                    w_state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_ack0_nxt  = ~r_grant_id;
                    w_ack1_nxt  =  r_grant_id;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = CNT_W'(RD_LAT);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    if (r_grant_id) begin
                        w_rdata1_nxt = q_ram;
                    end else begin
                        w_rdata0_nxt = q_ram;
                    end
                    w_ack0_nxt  = ~r_grant_id;
                    w_ack1_nxt  =  r_grant_id;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_last_grant  <= 1'b1;   // port 0 wins the first tie
            r_grant_id    <= 1'b0;
            r_address_ram <= '0;
            r_data_ram    <= '0;
            r_wren        <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_we          <= w_we_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_address_ram <= w_address_nxt;
            r_data_ram    <= w_data_nxt;
            r_wren        <= w_wren_nxt;
            r_ack0        <= w_ack0_nxt;
            r_ack1        <= w_ack1_nxt;
            r_rdata0      <= w_rdata0_nxt;
            r_rdata1      <= w_rdata1_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign address_ram = r_address_ram;
    assign data_ram    = r_data_ram;
    assign wren_ram    = r_wren;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. Three instances:
//               0: RD_LAT=1 round-robin, 1: RD_LAT=1 fixed priority,
//               2: RD_LAT=3 round-robin. Each has its own RAM model.
//               Expected acks are queued when stimulus is driven and
//               compared by a monitor when the DUT pulses ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int N = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic [N-1:0]       req0, we0, req1, we1, ack0, ack1, wren_ram, busy, grant_id;
    logic [N-1:0][15:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic [N-1:0][15:0] address_ram, data_ram;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    typedef struct {
        int          inst;
        int          port;
        int          cyc;
        logic [15:0] data;
        bit          rd;
    } exp_t;

    exp_t exq[$];

    // ------------------------------------------------------------------
    // DUT instances with RAM models
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int LAT = (g == 2) ? 3 : 1;
        logic [15:0] mem  [256];
        logic [15:0] pipe [LAT];
        logic [15:0] q;

        always @(posedge clock) begin
            if (wren_ram[g]) mem[address_ram[g][7:0]] <= data_ram[g];
            pipe[0] <= mem[address_ram[g][7:0]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign q = pipe[LAT-1];

        ram_arbiter #(
            .RD_LAT      (LAT),
            .PRIO0       ((g == 1) ? 1 : 0)
        ) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .req0        (req0[g]),
            .we0         (we0[g]),
            .addr0       (addr0[g]),
            .wdata0      (wdata0[g]),
            .ack0        (ack0[g]),
            .rdata0      (rdata0[g]),
            .req1        (req1[g]),
            .we1         (we1[g]),
            .addr1       (addr1[g]),
            .wdata1      (wdata1[g]),
            .ack1        (ack1[g]),
            .rdata1      (rdata1[g]),
            .address_ram (address_ram[g]),
            .data_ram    (data_ram[g]),
            .wren_ram    (wren_ram[g]),
            .q_ram       (q),
            .busy        (busy[g]),
            .grant_id    (grant_id[g])
        );
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic push(input int k, input int p, input int c, input logic [15:0] d, input bit rd);
        exp_t e;
        e.inst = k; e.port = p; e.cyc = c; e.data = d; e.rd = rd;
        exq.push_back(e);
    endtask

    task automatic see_ack(input int k, input int p, input logic [15:0] rd);
        exp_t e;
        chk($sformatf("ack_expected i%0d p%0d cyc%0d", k, p, ncyc), 32'(exq.size() != 0), 32'd1);
        if (exq.size() != 0) begin
            e = exq.pop_front();
            chk($sformatf("ack_inst i%0d p%0d", k, p), 32'(k), 32'(e.inst));
            chk($sformatf("ack_port i%0d p%0d", k, p), 32'(p), 32'(e.port));
            chk($sformatf("ack_cycle i%0d p%0d", k, p), 32'(ncyc), 32'(e.cyc));
            if (e.rd) chk($sformatf("ack_rdata i%0d p%0d", k, p), {16'h0, rd}, {16'h0, e.data});
        end
    endtask

    // Monitor: counts cycles and scores every ack pulse against the queue.
    always @(negedge clock) begin
        ncyc = ncyc + 1;
        for (int k = 0; k < N; k++) begin
            if (ack0[k] === 1'b1) see_ack(k, 0, rdata0[k]);
            if (ack1[k] === 1'b1) see_ack(k, 1, rdata1[k]);
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int d;
        reset_n = 1'b0;
        req0 = '0; we0 = '0; req1 = '0; we1 = '0;
        addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0;
        step(2);

        // Reset state
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_busy i%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_wren i%0d", k), 32'(wren_ram[k]), 32'd0);
            chk($sformatf("rst_acks i%0d", k), 32'({ack1[k], ack0[k]}), 32'd0);
            chk($sformatf("rst_rdata i%0d", k), {rdata1[k], rdata0[k]}, 32'd0);
            chk($sformatf("rst_addr_data i%0d", k), {address_ram[k], data_ram[k]}, 32'd0);
            chk($sformatf("rst_grant i%0d", k), 32'(grant_id[k]), 32'd0);
        end
        reset_n = 1'b1;
        step(1);

        // 1. Reset during a read WAIT (instance 2, RD_LAT=3)
        addr0[2] = 16'h0040; we0[2] = 1'b0; req0[2] = 1'b1;
        step(3);
        chk("t1_busy_in_wait", 32'(busy[2]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t1_async_wren", 32'(wren_ram[2]), 32'd0);
        chk("t1_async_busy", 32'(busy[2]), 32'd0);
        chk("t1_async_acks", 32'({ack1[2], ack0[2]}), 32'd0);
        chk("t1_async_addr", 32'(address_ram[2]), 32'd0);
        req0[2] = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(5);
        // Both request after release: port 0 first, then port 1
        addr0[2] = 16'h0030; wdata0[2] = 16'h5A5A; we0[2] = 1'b1;
        addr1[2] = 16'h0031; wdata1[2] = 16'hC3C3; we1[2] = 1'b1;
        req0[2] = 1'b1; req1[2] = 1'b1;
        d = ncyc;
        push(2, 0, d + 2, 16'h0, 1'b0);
        push(2, 1, d + 5, 16'h0, 1'b0);
        step(1);
        chk("t1_first_grant", 32'(grant_id[2]), 32'd0);
        step(1);
        req0[2] = 1'b0;
        step(2);
        chk("t1_second_grant", 32'(grant_id[2]), 32'd1);
        step(1);
        req1[2] = 1'b0;
        step(1);

        // 2. Port 0 write on instance 0
        addr0[0] = 16'h0010; wdata0[0] = 16'h1234; we0[0] = 1'b1; req0[0] = 1'b1;
        d = ncyc;
        push(0, 0, d + 2, 16'h0, 1'b0);
        step(1);
        chk("t2_wren_issue", 32'(wren_ram[0]), 32'd1);
        chk("t2_addr_issue", 32'(address_ram[0]), 32'h0010);
        chk("t2_data_issue", 32'(data_ram[0]), 32'h1234);
        step(1);
        chk("t2_wren_resp", 32'(wren_ram[0]), 32'd0);
        req0[0] = 1'b0;
        step(1);
        chk("t2_idle_busy", 32'(busy[0]), 32'd0);

        // 3. Port 1 read of the same word, RD_LAT=1
        addr1[0] = 16'h0010; we1[0] = 1'b0; req1[0] = 1'b1;
        d = ncyc;
        push(0, 1, d + 3, 16'h1234, 1'b1);
        step(1);
        chk("t3_wren_read", 32'(wren_ram[0]), 32'd0);
        step(2);
        chk("t3_rdata1", 32'(rdata1[0]), 32'h1234);
        chk("t3_rdata0_kept", 32'(rdata0[0]), 32'h0);
        req1[0] = 1'b0;
        step(1);

        // 4. Continuous writes from both ports, round-robin
        addr0[0] = 16'h0020; wdata0[0] = 16'hA000; we0[0] = 1'b1;
        addr1[0] = 16'h0021; wdata1[0] = 16'hB000; we1[0] = 1'b1;
        req0[0] = 1'b1; req1[0] = 1'b1;
        d = ncyc;
        for (int i = 0; i < 6; i++) push(0, i % 2, d + 2 + 3 * i, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("t4_grant_%0d", i), 32'(grant_id[0]), 32'(i % 2));
            chk($sformatf("t4_data_%0d", i), 32'(data_ram[0]), (i % 2 != 0) ? 32'hB000 : 32'hA000);
            step(1);
            if (i == 5) begin
                req0[0] = 1'b0; req1[0] = 1'b0;
            end
            step(1);
        end

        // 5. Fixed priority (instance 1): port 0 always wins, then port 1
        addr0[1] = 16'h0050; wdata0[1] = 16'h1111; we0[1] = 1'b1;
        addr1[1] = 16'h0051; wdata1[1] = 16'h2222; we1[1] = 1'b1;
        req0[1] = 1'b1; req1[1] = 1'b1;
        d = ncyc;
        for (int i = 0; i < 3; i++) push(1, 0, d + 2 + 3 * i, 16'h0, 1'b0);
        push(1, 1, d + 11, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("t5_grant_%0d", i), 32'(grant_id[1]), 32'd0);
            step(1);
            if (i == 2) req0[1] = 1'b0;
            step(1);
        end
        step(1);
        chk("t5_grant_port1", 32'(grant_id[1]), 32'd1);
        step(1);
        req1[1] = 1'b0;
        step(1);

        // 6. RD_LAT=3 reads on instance 2, second one with req dropped early
        addr0[2] = 16'h0030; we0[2] = 1'b0; req0[2] = 1'b1;
        d = ncyc;
        push(2, 0, d + 5, 16'h5A5A, 1'b1);
        step(5);
        chk("t6_rdata0_a", 32'(rdata0[2]), 32'h5A5A);
        req0[2] = 1'b0;
        step(1);
        addr0[2] = 16'h0031; req0[2] = 1'b1;
        d = ncyc;
        push(2, 0, d + 5, 16'hC3C3, 1'b1);
        step(2);
        req0[2] = 1'b0;
        step(3);
        chk("t6_rdata0_b", 32'(rdata0[2]), 32'hC3C3);
        chk("t6_rdata1_kept", 32'(rdata1[2]), 32'h0);
        step(4);

        chk("missing_acks", 32'(exq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
